datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Instruction-level controller for the 4-register, 4-bit DATAPATH. It accepts 10-bit macro-instructions over a valid/ready handshake and decodes each into one or more 13-bit control words. Multi-cycle instructions (load-immediate, swap) are expanded into several steps. It sits directly in front of DATAPATH: its ControlWord and ConstantIn outputs drive that block's inputs one-to-one, on the same CLK.

## Interface

No parameters; all widths are fixed by DATAPATH.

- CLK  input  1  rising-edge clock, shared with DATAPATH
- RST  input  1  synchronous, active-high reset
- InstrValid  input  1  instruction present on Instr
- Instr  input  10  {OP[9:6], RD[5:4], RA[3:2], RB[1:0]}
- Imm  input  4  immediate, sampled with Instr
- InstrReady  output  1  sequencer accepts Instr this cycle
- ControlWord  output  13  registered; [1:0]DA [3:2]AA [5:4]BA [6]MB [10:7]FS={Cin,S2,S1,S0} [11]MD [12]RW
- ConstantIn  output  4  registered Imm copy, drives DATAPATH ConstantIn
- Busy  output  1  multi-step instruction in progress
- Done  output  1  one-cycle pulse, co-incident with last control word of an instruction
- Illegal  output  1  one-cycle pulse, co-incident with the NOP word issued for OP=4'hF

## Operation

- FS meaning: S2=0 arithmetic, B-operand by {S1,S0}: 00→0000, 01→B, 10→~B, 11→1111, plus Cin. S2=1 logic, {S1,S0}: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- MB=1 selects ConstantIn. MD=1 selects DataIn. RW=1 writes the register at DA on the following CLK edge.
- Single-step ops (DA=RD, AA=RA, BA=RB, MB=0, MD=0, RW=1 unless noted):
  - 0 NOP: RW=0
  - 1 MOV: FS=0000
  - 2 ADD: 0001
  - 3 SUB: 1010
  - 4 INC: 1000
  - 5 DEC: 0011
  - 6 AND: 0100
  - 7 OR: 0101
  - 8 XOR: 0110
  - 9 NOT: 0111
  - A ADDI: FS=0001, MB=1
  - C LD: MD=1
  - D CLR: FS=0110, AA=BA=RD
  - F: issued as NOP, Illegal=1
- Multi-step ops:
  - B LDI: step0 = CLR RD; step1 = RD ← RD OR const (AA=RD, MB=1, FS=0101).
  - E SWAP RD,RA: three XOR steps.
    - step0: RD ← RD^RA
    - step1: RA ← RA^RD
    - step2: RD ← RD^RA
    - If RD==RA, all three steps are issued with RW=0.
- FSM states:
  - IDLE: ControlWord=0, so RW=0.
  - RUN: step counter 0..N-1, where N = 1/2/3 by opcode.
  - On accept, the instruction and Imm are latched. State goes RUN, step 0.
  - Leaving RUN: at step N-1, if a new instruction is accepted, go to RUN step 0 with the new instruction; otherwise go to IDLE.
- InstrReady is combinational: 1 in IDLE, or in RUN at step N-1 of the current instruction. It is 0 while RST=1.
- Busy = 1 in RUN when N>1 and step<N-1.
- InstrValid is ignored when InstrReady=0; the upstream block must hold Instr stable until accepted.

## Timing

- Reset values: ControlWord=0, ConstantIn=0, Done=0, Illegal=0, Busy=0, state=IDLE, step=0.
- RST asserted mid-instruction aborts it. No further RW=1 words are issued, even if a SWAP is only partly applied; DATAPATH register contents are not restored.
- Latency: instruction accepted at edge k → its first control word is valid from edge k until k+1 → DATAPATH writes at edge k+1.
- Throughput: single-step ops sustain one instruction per cycle. LDI takes 2 cycles; SWAP takes 3.
- ConstantIn changes only on accept and holds for all steps of that instruction.
- Done and Illegal are registered, aligned with the final ControlWord.
- A back-to-back accept in the final step produces no IDLE bubble.

## Test plan

- Reset behaviour: hold RST 2 cycles with InstrValid=1 → InstrReady=0, ControlWord=0 throughout. Ready=1 in the first cycle after release.
- Single-step stream with DATAPATH attached: LD R0 (DataIn=3), LD R1 (DataIn=5), ADD R2←R0+R1, SUB R3←R1−R0, issued back-to-back → Done on each of 4 consecutive cycles; final R2=8, R3=2.
- LDI R2,#9 then ADDI R2←R2+#7 → Busy=1 for exactly 1 cycle, InstrReady low for 1 cycle; R2=0 after step 0, 9 after step 1, then 0 (wrap, 4-bit).
- SWAP R0,R1 with R0=3, R1=5 → 3 control words, Done on the third; R0=5, R1=3. SWAP R2,R2 → all RW=0, R2 unchanged.
- OP=F, then NOT R1 (R1=5) → Illegal pulse with RW=0; then R1=A, with no Illegal pulse on the NOT.
- RST asserted during SWAP step 1 → next ControlWord=0; state IDLE; R0 keeps its step-0 value 3^5=6.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 4-register, 4-bit DATAPATH: turns 10-bit
// macro-instructions into one to three 13-bit control words per instruction.
module datapath_sequencer (
   input  logic        CLK,
   input  logic        RST,
   input  logic        InstrValid,
   input  logic [9:0]  Instr,
   input  logic [3:0]  Imm,
   output logic        InstrReady,
   output logic [12:0] ControlWord,
   output logic [3:0]  ConstantIn,
   output logic        Busy,
   output logic        Done,
   output logic        Illegal
);

   localparam int unsigned INSTR_W = 10;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned FS_W    = 4;
   localparam int unsigned STEP_W  = 2;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
   localparam logic [OP_W-1:0] OP_INC  = 4'h4;
   localparam logic [OP_W-1:0] OP_DEC  = 4'h5;
   localparam logic [OP_W-1:0] OP_AND  = 4'h6;
   localparam logic [OP_W-1:0] OP_OR   = 4'h7;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
   localparam logic [OP_W-1:0] OP_NOT  = 4'h9;
   localparam logic [OP_W-1:0] OP_ADDI = 4'hA;
   localparam logic [OP_W-1:0] OP_LDI  = 4'hB;
   localparam logic [OP_W-1:0] OP_LD   = 4'hC;
   localparam logic [OP_W-1:0] OP_CLR  = 4'hD;
   localparam logic [OP_W-1:0] OP_SWAP = 4'hE;
   localparam logic [OP_W-1:0] OP_ILL  = 4'hF;

   // FS = {Cin, S2, S1, S0}
   localparam logic [FS_W-1:0] FS_PASS = 4'b0000;
   localparam logic [FS_W-1:0] FS_ADD  = 4'b0001;
   localparam logic [FS_W-1:0] FS_SUB  = 4'b1010;
   localparam logic [FS_W-1:0] FS_INC  = 4'b1000;
   localparam logic [FS_W-1:0] FS_DEC  = 4'b0011;
   localparam logic [FS_W-1:0] FS_AND  = 4'b0100;
   localparam logic [FS_W-1:0] FS_OR   = 4'b0101;
   localparam logic [FS_W-1:0] FS_XOR  = 4'b0110;
   localparam logic [FS_W-1:0] FS_NOT  = 4'b0111;

   typedef struct packed {
      logic             rw;
      logic             md;
      logic [FS_W-1:0]  fs;
      logic             mb;
      logic [SEL_W-1:0] ba;
      logic [SEL_W-1:0] aa;
      logic [SEL_W-1:0] da;
   } cw_t;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [STEP_W-1:0]   step;
   logic [STEP_W-1:0]   step_nxt;
   logic [INSTR_W-1:0]  cur_instr;
   cw_t                 cw_q;
   logic                accept;

   // Index of the final step: LDI has two steps, SWAP three, everything else one.
   function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
      case (op)
         OP_LDI:  return 2'd1;
         OP_SWAP: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Control word for a given instruction and step.
   function automatic cw_t decode(input logic [INSTR_W-1:0] ins,
                                  input logic [STEP_W-1:0]  stp);
      cw_t              w;
      logic [OP_W-1:0]  op;
      logic [SEL_W-1:0] rd;
      logic [SEL_W-1:0] ra;
      logic [SEL_W-1:0] rb;
      op   = ins[9:6];
      rd   = ins[5:4];
      ra   = ins[3:2];
      rb   = ins[1:0];
      w.rw = 1'b1;
      w.md = 1'b0;
      w.fs = FS_PASS;
      w.mb = 1'b0;
      w.ba = rb;
      w.aa = ra;
      w.da = rd;
      case (op)
         OP_NOP:  w.rw = 1'b0;
         OP_MOV:  w.fs = FS_PASS;
         OP_ADD:  w.fs = FS_ADD;
         OP_SUB:  w.fs = FS_SUB;
         OP_INC:  w.fs = FS_INC;
         OP_DEC:  w.fs = FS_DEC;
         OP_AND:  w.fs = FS_AND;
         OP_OR:   w.fs = FS_OR;
         OP_XOR:  w.fs = FS_XOR;
         OP_NOT:  w.fs = FS_NOT;
         OP_ADDI: begin
            w.fs = FS_ADD;
            w.mb = 1'b1;
         end
         OP_LDI: begin
            // Clear RD, then OR the constant into it.
            w.aa = rd;
            if (stp == 2'd0) begin
               w.fs = FS_XOR;
               w.ba = rd;
            end else begin
               w.fs = FS_OR;
               w.mb = 1'b1;
            end
         end
         OP_LD:   w.md = 1'b1;
         OP_CLR: begin
            w.fs = FS_XOR;
            w.aa = rd;
            w.ba = rd;
         end
         OP_SWAP: begin
            // XOR swap; with RD==RA it would zero the register, so writes are suppressed.
            w.fs = FS_XOR;
            w.rw = (rd != ra);
            if (stp == 2'd1) begin
               w.da = ra;
               w.aa = ra;
               w.ba = rd;
            end else begin
               w.aa = rd;
               w.ba = ra;
            end
         end
         OP_ILL:  w.rw = 1'b0;
         default: w.rw = 1'b0;
      endcase
      return w;
   endfunction

   assign step_nxt    = step + 2'd1;
   assign InstrReady  = !RST && ((state == IDLE) || (step == last_step(cur_instr[9:6])));
   assign accept      = InstrValid && InstrReady;
   assign ControlWord = cw_q;

   // Sequencer state and registered control outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         step       <= '0;
         cur_instr  <= '0;
         cw_q       <= '0;
         ConstantIn <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Illegal    <= 1'b0;
      end else if (accept) begin
         state      <= RUN;
         step       <= '0;
         cur_instr  <= Instr;
         cw_q       <= decode(Instr, 2'd0);
         ConstantIn <= Imm;
         Busy       <= (last_step(Instr[9:6]) != 2'd0);
         Done       <= (last_step(Instr[9:6]) == 2'd0);
         Illegal    <= (Instr[9:6] == OP_ILL);
      end else if ((state == RUN) && (step != last_step(cur_instr[9:6]))) begin
         step       <= step_nxt;
         cw_q       <= decode(cur_instr, step_nxt);
         Busy       <= (step_nxt != last_step(cur_instr[9:6]));
         Done       <= (step_nxt == last_step(cur_instr[9:6]));
         Illegal    <= 1'b0;
      end else begin
         state      <= IDLE;
         step       <= '0;
         cw_q       <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Illegal    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: drives it with an attached DATAPATH model and
// checks outputs against an instruction-level reference model.
module tb_datapath_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        InstrValid = 1'b0;
   logic [9:0]  Instr = '0;
   logic [3:0]  Imm = '0;
   logic        InstrReady;
   logic [12:0] ControlWord;
   logic [3:0]  ConstantIn;
   logic        Busy;
   logic        Done;
   logic        Illegal;

   datapath_sequencer dut (
      .CLK(CLK), .RST(RST), .InstrValid(InstrValid), .Instr(Instr), .Imm(Imm),
      .InstrReady(InstrReady), .ControlWord(ControlWord), .ConstantIn(ConstantIn),
      .Busy(Busy), .Done(Done), .Illegal(Illegal)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [3:0] rf     [4] = '{default: 4'h0};
   logic [3:0] isa_rf [4] = '{default: 4'h0};
   logic [3:0] din_drv = '0;
   logic [3:0] din_cur = '0;

   logic        s_rst = 1'b1;
   logic        s_acc = 1'b0;
   logic [9:0]  s_instr = '0;
   logic [3:0]  s_imm = '0;
   logic [3:0]  s_din = '0;
   logic [12:0] s_cw = '0;
   logic [3:0]  s_const = '0;

   bit         act = 1'b0;
   int         k = 0;
   logic [3:0] m_op = '0;
   logic [1:0] m_rd = '0;
   logic [1:0] m_ra = '0;
   logic [3:0] exp_const = '0;
   bit         m_last;
   bit         rw_exp;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int n_of(input logic [3:0] op);
      if (op == 4'hB) return 2;
      if (op == 4'hE) return 3;
      return 1;
   endfunction

   // DATAPATH behaviour: function unit result then DataIn mux.
   function automatic logic [3:0] dp_result(input logic [12:0] cw, input logic [3:0] c,
                                            input logic [3:0] din);
      logic [3:0] a, b, bs, y;
      a = rf[cw[3:2]];
      b = cw[6] ? c : rf[cw[5:4]];
      bs = 4'h0;
      if (!cw[9]) begin
         case (cw[8:7])
            2'd0: bs = 4'h0;
            2'd1: bs = b;
            2'd2: bs = ~b;
            default: bs = 4'hF;
         endcase
         y = a + bs + {3'b000, cw[10]};
      end else begin
         case (cw[8:7])
            2'd0: y = a & b;
            2'd1: y = a | b;
            2'd2: y = a ^ b;
            default: y = ~a;
         endcase
      end
      return cw[11] ? din : y;
   endfunction

   // Architectural effect of a whole instruction.
   task automatic isa_apply(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                            input logic [1:0] rb, input logic [3:0] imm, input logic [3:0] din);
      logic [3:0] t;
      case (op)
         4'h1: isa_rf[rd] = isa_rf[ra];
         4'h2: isa_rf[rd] = isa_rf[ra] + isa_rf[rb];
         4'h3: isa_rf[rd] = isa_rf[ra] - isa_rf[rb];
         4'h4: isa_rf[rd] = isa_rf[ra] + 4'd1;
         4'h5: isa_rf[rd] = isa_rf[ra] - 4'd1;
         4'h6: isa_rf[rd] = isa_rf[ra] & isa_rf[rb];
         4'h7: isa_rf[rd] = isa_rf[ra] | isa_rf[rb];
         4'h8: isa_rf[rd] = isa_rf[ra] ^ isa_rf[rb];
         4'h9: isa_rf[rd] = ~isa_rf[ra];
         4'hA: isa_rf[rd] = isa_rf[ra] + imm;
         4'hB: isa_rf[rd] = imm;
         4'hC: isa_rf[rd] = din;
         4'hD: isa_rf[rd] = 4'h0;
         4'hE: begin
            t = isa_rf[rd];
            isa_rf[rd] = isa_rf[ra];
            isa_rf[ra] = t;
         end
         default: ;
      endcase
   endtask

   // Sample bus and check timing/outputs away from the active edge.
   always @(negedge CLK) begin
      s_rst   = RST;
      s_acc   = InstrValid && InstrReady;
      s_instr = Instr;
      s_imm   = Imm;
      s_din   = din_drv;
      s_cw    = ControlWord;
      s_const = ConstantIn;
      if (chk_en) begin
         m_last = act && (k == n_of(m_op) - 1);
         check("ready",   16'(InstrReady), 16'(!RST && (!act || m_last)));
         check("busy",    16'(Busy),       16'(act && (k < n_of(m_op) - 1)));
         check("done",    16'(Done),       16'(m_last));
         check("illegal", 16'(Illegal),    16'(act && (m_op == 4'hF)));
         check("const",   16'(ConstantIn), 16'(exp_const));
         if (!act) begin
            check("cw_idle", 16'(ControlWord), 16'h0);
            if (!RST)
               for (int i = 0; i < 4; i++) check("regfile", 16'(rf[i]), 16'(isa_rf[i]));
         end else begin
            rw_exp = !((m_op == 4'h0) || (m_op == 4'hF) || ((m_op == 4'hE) && (m_rd == m_ra)));
            check("rw", 16'(ControlWord[12]), 16'(rw_exp));
         end
      end
   end

   // DATAPATH register writes and sequencer timing model.
   always @(posedge CLK) begin
      if (s_cw[12]) rf[s_cw[1:0]] <= dp_result(s_cw, s_const, din_cur);
      if (s_acc) din_cur <= s_din;
      if (s_rst) begin
         act <= 1'b0;
         k <= 0;
         exp_const <= '0;
      end else if (act && (k < n_of(m_op) - 1)) begin
         k <= k + 1;
      end else if (s_acc) begin
         act <= 1'b1;
         k <= 0;
         m_op <= s_instr[9:6];
         m_rd <= s_instr[5:4];
         m_ra <= s_instr[3:2];
         exp_const <= s_imm;
      end else begin
         act <= 1'b0;
         k <= 0;
      end
   end

   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [3:0] imm, input logic [3:0] din);
      bit ok;
      ok = 1'b0;
      InstrValid = 1'b1;
      Instr = {op, rd, ra, rb};
      Imm = imm;
      din_drv = din;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge CLK);
         if (InstrReady) ok = 1'b1;
      end
      check("accept_timeout", 16'(ok), 16'h1);
      if (ok) begin
         @(posedge CLK);
         #1;
         isa_apply(op, rd, ra, rb, imm, din);
      end else begin
         InstrValid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      InstrValid = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held two cycles with a valid instruction waiting.
      InstrValid = 1'b1;
      Instr = {4'h2, 2'd0, 2'd1, 2'd2};
      @(posedge CLK);
      #1;
      chk_en = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      InstrValid = 1'b0;
      @(negedge CLK);
      check("ready_after_reset", 16'(InstrReady), 16'h1);
      @(posedge CLK);
      #1;

      // Back-to-back single-step stream.
      issue(4'hC, 2'd0, 2'd0, 2'd0, 4'h0, 4'd3);
      issue(4'hC, 2'd1, 2'd0, 2'd0, 4'h0, 4'd5);
      issue(4'h2, 2'd2, 2'd0, 2'd1, 4'h0, 4'd0);
      issue(4'h3, 2'd3, 2'd1, 2'd0, 4'h0, 4'd0);
      wait_idle();
      check("stream_r2", 16'(rf[2]), 16'd8);
      check("stream_r3", 16'(rf[3]), 16'd2);

      // LDI R2,#9 followed directly by ADDI R2,R2,#7.
      issue(4'hB, 2'd2, 2'd0, 2'd0, 4'd9, 4'd0);
      InstrValid = 1'b0;
      @(posedge CLK);
      #1;
      check("ldi_step0", 16'(rf[2]), 16'd0);
      issue(4'hA, 2'd2, 2'd2, 2'd0, 4'd7, 4'd0);
      check("ldi_step1", 16'(rf[2]), 16'd9);
      wait_idle();
      check("addi_wrap", 16'(rf[2]), 16'd0);

      // SWAP R0,R1 and a self-swap.
      issue(4'hE, 2'd0, 2'd1, 2'd0, 4'h0, 4'd0);
      wait_idle();
      check("swap_r0", 16'(rf[0]), 16'd5);
      check("swap_r1", 16'(rf[1]), 16'd3);
      issue(4'hE, 2'd2, 2'd2, 2'd0, 4'h0, 4'd0);
      wait_idle();
      check("swap_self", 16'(rf[2]), 16'd0);

      // Illegal opcode followed by NOT.
      issue(4'hC, 2'd1, 2'd0, 2'd0, 4'h0, 4'd5);
      issue(4'hF, 2'd1, 2'd1, 2'd1, 4'h0, 4'd0);
      issue(4'h9, 2'd1, 2'd1, 2'd0, 4'h0, 4'd0);
      wait_idle();
      check("not_r1", 16'(rf[1]), 16'hA);

      // Reset during SWAP step 1.
      issue(4'hC, 2'd0, 2'd0, 2'd0, 4'h0, 4'd3);
      issue(4'hC, 2'd1, 2'd0, 2'd0, 4'h0, 4'd5);
      issue(4'hE, 2'd0, 2'd1, 2'd0, 4'h0, 4'd0);
      InstrValid = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      isa_rf[0] = 4'd6;
      isa_rf[1] = 4'd5 ^ 4'd6;
      @(posedge CLK);
      #1;
      check("abort_cw", 16'(ControlWord), 16'h0);
      check("abort_r0", 16'(rf[0]), 16'd6);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_idle();

      // Randomized instruction stream with occasional idle gaps.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            InstrValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
         end
         issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      wait_idle();
      for (int i = 0; i < 4; i++) check("final_rf", 16'(rf[i]), 16'(isa_rf[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
